enc_binder_seq_pack: RTL

// Parametrised, time-multiplexed successor of the fixed per-core binder packs.
// - Binds NUM_FEAT level HVs by circular rotation. Feature i uses the shift SHIFTS[SHIFT_BASE+i] from the shared shift package.
// - Processes LANES features per cycle, trading latency for area.
// - Sits between the level-HV lookup and the bundler. Adds a start/busy/done handshake and a registered output bank.

---
 rtl/enc_binder_seq_pack_if.sv | 50 +++++
 rtl/enc_binder_seq_pack.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/enc_binder_seq_pack_if.sv
// enc_binder_seq_pack_if
// Handshake and data bus between the level-HV lookup (master) and the
// time-multiplexed binder pack (slave).
//
// Handshake: start_encoding is a request that the binder accepts only while it
// is idle; busy is high from the accepting edge until the binder returns to idle.
// done is a one-cycle pulse marking a complete bank. out_valid then stays high
// until the next accepted start. level_hv only has to be stable on the accepting
// edge.
//
// Signals
//   start_encoding  master->slave  request, sampled only while idle
//   level_hv        master->slave  NUM_FEAT level HVs, captured on accept
//   busy            slave->master  high while binding and in the done cycle
//   done            slave->master  one-cycle completion pulse
//   out_valid       slave->master  shifted_hv bank complete and stable
//   shifted_hv      slave->master  NUM_FEAT bound HVs (registered)
//   bind_err        slave->master  sticky parity-mismatch flag
interface enc_binder_seq_pack_if #(
    parameter int HV_DIM   = 1024,
    parameter int NUM_FEAT = 8
);
    logic              start_encoding;
    logic [HV_DIM-1:0] level_hv   [NUM_FEAT];
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [HV_DIM-1:0] shifted_hv [NUM_FEAT];
    logic              bind_err;

    modport master (
        output start_encoding,
        output level_hv,
        input  busy,
        input  done,
        input  out_valid,
        input  shifted_hv,
        input  bind_err
    );

    modport slave (
        input  start_encoding,
        input  level_hv,
        output busy,
        output done,
        output out_valid,
        output shifted_hv,
        output bind_err
    );
endinterface

// File: rtl/enc_binder_seq_pack.sv
// enc_binder_seq_pack
// Time-multiplexed binder pack. Binds NUM_FEAT level HVs by rotating each one
// toward the MSB by its own shift amount, LANES features per clock.
// Feature i rotates by SHIFTS[SHIFT_BASE+i] % HV_DIM, taken from enc_shift_pkg.
// The rotation maps out[(j+S)%HV_DIM] = in[j].
//
// Operation
//   IDLE -> BIND -> DONE -> IDLE. In IDLE, an accepted start captures every
//   level HV into an input bank. In BIND, each clock writes up to LANES features
//   into the registered output bank, for ceil(NUM_FEAT/LANES) steps. DONE lasts
//   one cycle: done pulses there and out_valid rises and stays high.
//
// Optional feature (macro ENC_BINDER_PARITY_CHK_EN)
//   When the macro is defined, every written feature compares the XOR-reduction
//   of its input HV against that of its rotated HV. A mismatch sets a sticky
//   bind_err, which only reset clears. When the macro is undefined, bind_err is
//   tied low and no parity logic is built.
//
// Ports
//   clk        in   rising-edge clock
//   nrst       in   asynchronous active-low reset
//   bus        slave modport of enc_binder_seq_pack_if
//   dbg_state  out  current FSM state (0=IDLE, 1=BIND, 2=DONE)

package enc_shift_pkg;
    localparam int unsigned NUM_SHIFTS = 32;
    localparam int unsigned SHIFTS [NUM_SHIFTS] = '{
          0,   1,   3,   5,   7,  11,  13,  17,
         19,  23,  29,  31,  37,  41,  43,  47,
         53,  59,  61,  67,  71,  73,  79,  83,
         89,  97, 101, 103, 107, 109, 113, 127
    };
endpackage

module enc_binder_seq_pack
    import enc_shift_pkg::*;
#(
    parameter int HV_DIM     = 1024,
    parameter int NUM_FEAT   = 8,
    parameter int LANES      = 2,
    parameter int SHIFT_BASE = 0
) (
    input  logic                  clk,
    input  logic                  nrst,
    enc_binder_seq_pack_if.slave  bus,
    output logic [1:0]            dbg_state
);

    localparam int N_STEPS = (NUM_FEAT + LANES - 1) / LANES;
    localparam int STEP_W  = $clog2(N_STEPS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BIND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [STEP_W-1:0]   step;
    logic [HV_DIM-1:0]   in_bank  [NUM_FEAT];
    logic [HV_DIM-1:0]   out_bank [NUM_FEAT];
    logic                busy_q;
    logic                done_q;
    logic                out_valid_q;

    // Per-lane datapath for the current step.
    int                  lane_f  [LANES];
    logic [LANES-1:0]    lane_en;
    logic [HV_DIM-1:0]   lane_in [LANES];
    int unsigned         lane_sh [LANES];
    logic [LANES-1:0][HV_DIM-1:0] rot_hv;

    function automatic int unsigned shift_of(input int f);
        return SHIFTS[SHIFT_BASE + f] % HV_DIM;
    endfunction

    // Lane k serves feature step*LANES+k. Features past NUM_FEAT exist only in
    // the last partial step; those lanes are disabled and write nothing.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_f[k]  = int'(step) * LANES + k;
            lane_en[k] = (lane_f[k] < NUM_FEAT);
            lane_in[k] = '0;
            lane_sh[k] = 0;
            for (int f = 0; f < NUM_FEAT; f++) begin
                if (lane_f[k] == f) begin
                    lane_in[k] = in_bank[f];
                    lane_sh[k] = shift_of(f);
                end
            end
            // A zero shift is special-cased. Otherwise the wrap term would
            // shift right by the full vector width.
            if (lane_sh[k] == 0) begin
                rot_hv[k] = lane_in[k];
            end else begin
                rot_hv[k] = (lane_in[k] << lane_sh[k])
                          | (lane_in[k] >> (HV_DIM - lane_sh[k]));
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_IDLE;
            step        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            for (int f = 0; f < NUM_FEAT; f++) begin
                in_bank[f]  <= '0;
                out_bank[f] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_encoding) begin
                        for (int f = 0; f < NUM_FEAT; f++) begin
                            in_bank[f] <= bus.level_hv[f];
                        end
                        step        <= '0;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                        state       <= S_BIND;
                    end
                end
                S_BIND: begin
                    for (int f = 0; f < NUM_FEAT; f++) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (lane_en[k] && (lane_f[k] == f)) begin
                                out_bank[f] <= rot_hv[k];
                            end
                        end
                    end
                    if (step == LAST_STEP) begin
                        step        <= '0;
                        done_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                S_DONE: begin
                    // No start is sampled here, so a request on this edge is ignored.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ENC_BINDER_PARITY_CHK_EN
    logic bind_err_q;

    // Rotation preserves parity, so a mismatch means the rotator is corrupt.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bind_err_q <= 1'b0;
        end else if (state == S_BIND) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_en[k] && ((^lane_in[k]) != (^rot_hv[k]))) begin
                    bind_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.bind_err = bind_err_q;
`else
    assign bus.bind_err = 1'b0;
`endif

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign dbg_state     = state;

    for (genvar g = 0; g < NUM_FEAT; g++) begin : g_out
        assign bus.shifted_hv[g] = out_bank[g];
    end

endmodule
